// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits (LSB first), optional parity,
// 1 or 2 stop bits. Bit timing comes from an external oversampling tick.
// cts_n gates only the acceptance of a new frame, never a frame in flight.
module uart_tx #(
   parameter int OS_TICKS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic [1:0] data_bit_num,
   input  logic       stop_bit_num,
   input  logic       parity_en,
   input  logic       parity_type,
   input  logic       cts_n,
   output logic       tx,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int TW = (OS_TICKS > 1) ? $clog2(OS_TICKS) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state, state_nx;
   logic [TW-1:0] tick_cnt;
   logic [2:0]    count_data;
   logic          stop_cnt;

   // frame configuration captured at acceptance
   logic [7:0]    data_q;
   logic [2:0]    last_idx_q;
   logic          stop2_q;
   logic          par_en_q;
   logic          par_bit_q;

   logic [7:0]    data_mask;
   logic [2:0]    nxt_idx;
   logic          accept;
   logic          bit_end;
   logic          tx_nx;
   logic          done_nx;

   assign tx_ready  = (state == IDLE) && !cts_n;
   assign tx_busy   = (state != IDLE);
   assign accept    = tx_ready && tx_start;
   assign bit_end   = (state != IDLE) && tick && (tick_cnt == TW'(OS_TICKS - 1));
   // bits above the configured width are dropped so they never reach the line or parity
   assign data_mask = 8'hFF >> (2'd3 - data_bit_num);
   assign nxt_idx   = count_data + 3'd1;

   // state, serial line and completion pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx      <= 1'b1;
         tx_done <= 1'b0;
      end else begin
         state   <= state_nx;
         tx      <= tx_nx;
         tx_done <= done_nx;
      end
   end

   // next state plus the line level that the next state will drive
   always_comb begin
      state_nx = state;
      tx_nx    = tx;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            tx_nx = 1'b1;
            if (accept) begin
               state_nx = START;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nx = DATA;
               tx_nx    = data_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (count_data == last_idx_q) begin
                  if (par_en_q) begin
                     state_nx = PARITY;
                     tx_nx    = par_bit_q;
                  end else begin
                     state_nx = STOP;
                     tx_nx    = 1'b1;
                  end
               end else begin
                  tx_nx = data_q[nxt_idx];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nx = STOP;
               tx_nx    = 1'b1;
            end
         end
         STOP: begin
            tx_nx = 1'b1;
            if (bit_end && (stop_cnt == stop2_q)) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
         end
      endcase
   end

   // oversample tick counter and per-frame bit counters; all hold while tick=0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt   <= '0;
         count_data <= '0;
         stop_cnt   <= 1'b0;
      end else if (accept) begin
         tick_cnt   <= '0;
         count_data <= '0;
         stop_cnt   <= 1'b0;
      end else if (bit_end) begin
         tick_cnt <= '0;
         if (state == DATA) count_data <= nxt_idx;
         if (state == STOP) stop_cnt   <= 1'b1;
      end else if (tick && state != IDLE) begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   // capture payload and framing options once per frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q     <= '0;
         last_idx_q <= '0;
         stop2_q    <= 1'b0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
      end else if (accept) begin
         data_q     <= tx_data & data_mask;
         last_idx_q <= {1'b1, data_bit_num};
         stop2_q    <= stop_bit_num;
         par_en_q   <= parity_en;
         // even: XOR of sent bits; odd: its inverse
         par_bit_q  <= (^(tx_data & data_mask)) ^ ~parity_type;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model (queue of line bits, each held
// OS_TICKS ticks) predicts tx/tx_busy/tx_done/tx_ready every cycle; directed
// frames pin the model against hand-computed bit patterns and durations.
module tb_uart_tx;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = '0;
   logic [1:0] data_bit_num = '0;
   logic       stop_bit_num = 1'b0;
   logic       parity_en = 1'b0;
   logic       parity_type = 1'b0;
   logic       cts_n = 1'b0;
   logic       tx, tx_ready, tx_busy, tx_done;

   int vectors = 0;
   int miscompares = 0;
   int dut_ticks = 0;

   uart_tx #(.OS_TICKS(OS)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(tx_start),
      .tx_data(tx_data), .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
      .parity_en(parity_en), .parity_type(parity_type), .cts_n(cts_n),
      .tx(tx), .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit m_busy = 0;
   bit m_done = 0;
   bit m_q[$];
   bit last_bits[$];
   int m_tk = 0;
   int m_frame_ticks = 0;
   int last_frame_ticks = 0;
   int m_frames = 0;

   task automatic m_build();
      int n;
      bit p;
      n = 5 + int'(data_bit_num);
      p = 0;
      m_q.delete();
      m_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         m_q.push_back(tx_data[i]);
         p = p ^ tx_data[i];
      end
      if (parity_en) m_q.push_back(parity_type ? p : ~p);
      m_q.push_back(1'b1);
      if (stop_bit_num) m_q.push_back(1'b1);
      last_bits = m_q;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; m_done = 0; m_tk = 0; m_q.delete();
         end else begin
            m_done = 0;
            if (!m_busy) begin
               if (tx_start && !cts_n) begin
                  m_build();
                  m_busy = 1; m_tk = 0; m_frame_ticks = 0;
               end
            end else if (tick) begin
               m_tk++; m_frame_ticks++;
               if (m_tk == OS) begin
                  m_tk = 0;
                  void'(m_q.pop_front());
                  if (m_q.size() == 0) begin
                     m_busy = 0; m_done = 1;
                     last_frame_ticks = m_frame_ticks;
                     m_frames++;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pack(input bit q[$]);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < q.size() && i < 16; i++) r[i] = q[i];
      return r;
   endfunction

   // per-cycle compare, mid-cycle away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("tx", tx, m_busy ? m_q[0] : 1'b1);
            check("tx_busy", tx_busy, m_busy);
            check("tx_done", tx_done, m_done);
            check("tx_ready", tx_ready, !m_busy && !cts_n);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      if (tx_busy && tick) dut_ticks++;
      @(posedge clk);
      #2;
      tick = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_done(input string name);
      int i;
      i = 0;
      while (!tx_done && i < 4000) begin
         cyc();
         i++;
      end
      check({name, " done"}, tx_done, 1'b1);
   endtask

   task automatic send(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                       input logic pe, input logic pt);
      tx_data = d; data_bit_num = dbn; stop_bit_num = sb;
      parity_en = pe; parity_type = pt; tx_start = 1'b1;
      dut_ticks = 0;
      cyc();
      tx_start = 1'b0;
   endtask

   task automatic pin(input string name, input logic [15:0] bits, input int len, input int ticks);
      check({name, " bits"}, pack(last_bits), bits);
      check({name, " len"}, last_bits.size(), len);
      check({name, " model ticks"}, last_frame_ticks, ticks);
      check({name, " dut ticks"}, dut_ticks, ticks);
   endtask

   initial begin
      repeat (3) cyc();
      check("rst tx", tx, 1'b1);
      check("rst busy", tx_busy, 1'b0);
      rst_n = 1'b1;
      cyc();
      check("post-rst tx", tx, 1'b1);
      check("post-rst ready", tx_ready, 1'b1);
      check("post-rst done", tx_done, 1'b0);

      // 8N1 0xA5
      send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
      wait_done("8N1");
      pin("8N1", 16'h034A, 10, 160);

      // 5E1 0xF3, upper bits ignored
      send(8'hF3, 2'b00, 1'b0, 1'b1, 1'b1);
      wait_done("5E1");
      pin("5E1", 16'h00E6, 8, 128);

      // 7O2 0x00
      send(8'h00, 2'b10, 1'b1, 1'b1, 1'b0);
      wait_done("7O2");
      pin("7O2", 16'h0700, 11, 176);

      // flow control: blocked request is not queued
      cts_n = 1'b1;
      tx_start = 1'b1;
      cyc();
      tx_start = 1'b0;
      repeat (40) cyc();
      check("cts blocked busy", tx_busy, 1'b0);
      check("cts blocked tx", tx, 1'b1);
      cts_n = 1'b0;

      // cts_n released mid-frame does not disturb the frame
      send(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0);
      repeat (40) cyc();
      cts_n = 1'b1;
      wait_done("cts mid");
      pin("cts mid", 16'h02B4, 10, 160);
      tx_start = 1'b1;
      repeat (30) cyc();
      check("cts held busy", tx_busy, 1'b0);
      tx_start = 1'b0;
      cts_n = 1'b0;

      // back-to-back with tx_start held, config scrambled during frame 1
      tx_data = 8'hA5; data_bit_num = 2'b11; stop_bit_num = 1'b0; parity_en = 1'b0;
      tx_start = 1'b1;
      dut_ticks = 0;
      cyc();
      begin
         int i;
         i = 0;
         while (!tx_done && i < 4000) begin
            tx_data = 8'($urandom); data_bit_num = 2'($urandom);
            stop_bit_num = 1'($urandom); parity_en = 1'($urandom); parity_type = 1'($urandom);
            cyc();
            i++;
         end
      end
      check("b2b done", tx_done, 1'b1);
      pin("b2b f1", 16'h034A, 10, 160);
      cyc();
      check("b2b start tx", tx, 1'b0);
      check("b2b start busy", tx_busy, 1'b1);
      tx_start = 1'b0;
      wait_done("b2b f2");

      // reset in the middle of DATA
      send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
      tick = 1'b1;
      repeat (30) begin
         @(posedge clk); #2; tick = 1'b1;
      end
      check("pre-rst tx low", tx, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async rst tx", tx, 1'b1);
      check("async rst busy", tx_busy, 1'b0);
      check("async rst done", tx_done, 1'b0);
      repeat (3) cyc();
      check("rst hold done", tx_done, 1'b0);
      rst_n = 1'b1;
      send(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
      wait_done("post-rst 3C");
      pin("post-rst 3C", 16'h0278, 10, 160);

      // randomized traffic
      for (int c = 0; c < 7000; c++) begin
         tx_start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) cts_n = ~cts_n;
         tx_data = 8'($urandom); data_bit_num = 2'($urandom);
         stop_bit_num = 1'($urandom); parity_en = 1'($urandom); parity_type = 1'($urandom);
         cyc();
      end
      check("random frames seen", (m_frames > 15), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got time %0t expected < 2000000", $time);
      $fatal(1);
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL take parameter OS_TICKS, default 16, giving the number of tick pulses per transmitted bit.
REQ-002 The block SHALL have input clk, 1 bit: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have input tick, 1 bit: one-clk-wide baud pulse at OS_TICKS x baud rate.
REQ-005 The block SHALL have input tx_start, 1 bit: frame request, sampled on clk.
REQ-006 The block SHALL have input tx_data, 8 bits: payload, LSB transmitted first.
REQ-007 The block SHALL have input data_bit_num, 2 bits: payload width, where 00=5, 01=6, 10=7 and 11=8 bits.
REQ-008 The block SHALL have input stop_bit_num, 1 bit: stop bits, where 0=1 and 1=2.
REQ-009 The block SHALL have input parity_en, 1 bit: 1 inserts a parity bit after the data bits.
REQ-010 The block SHALL have input parity_type, 1 bit: 1=even, 0=odd.
REQ-011 The block SHALL have input cts_n, 1 bit: active-low clear-to-send from the far receiver.
REQ-012 The block SHALL have output tx, 1 bit: serial line, idle high.
REQ-013 The block SHALL have output tx_ready, 1 bit: high when a tx_start would be accepted.
REQ-014 The block SHALL have output tx_busy, 1 bit: high while a frame is in progress.
REQ-015 The block SHALL have output tx_done, 1 bit: one-clk pulse at frame completion.

Function
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with IDLE as the reset state.
REQ-017 tx_ready SHALL equal (state==IDLE && cts_n==0), combinationally.
REQ-018 In IDLE, tx_start=1 with tx_ready=1 SHALL latch tx_data, data_bit_num, stop_bit_num, parity_en and parity_type, and enter START on the next edge.
REQ-019 tx_start SHALL be ignored when tx_ready=0, with no queuing.
REQ-020 Config inputs SHALL be ignored after acceptance until the next acceptance.
REQ-021 tx SHALL be registered: 1 in IDLE, 0 in START, data bit count_data in DATA, parity bit in PARITY, and 1 in STOP.
REQ-022 The tick counter SHALL run 0..OS_TICKS-1, advance only on tick=1 outside IDLE, and clear on entry to each bit.
REQ-023 Each bit period SHALL end on the clk where tick=1 and tick counter==OS_TICKS-1, so every bit lasts exactly OS_TICKS ticks.
REQ-024 START SHALL transition to DATA at the end of its bit period.
REQ-025 DATA SHALL increment count_data at the end of each bit period.
REQ-026 After data bit N-1, DATA SHALL go to PARITY if parity_en was latched as 1, else to STOP.
REQ-027 PARITY SHALL go to STOP after one bit period.
REQ-028 The parity bit SHALL be the XOR of the N transmitted data bits for even parity, and the inverse of that XOR for odd parity.
REQ-029 Data bits above position N-1 SHALL be neither sent nor included in parity.
REQ-030 STOP SHALL last 1 or 2 bit periods per the latched stop count, then return to IDLE.
REQ-031 tx_done SHALL be 1 for exactly the clk after the final stop-bit period ends, coincident with the first IDLE cycle.
REQ-032 tx_busy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-033 Frame duration SHALL be OS_TICKS*(1+N+P+S) ticks, with P in {0,1} and S in {1,2}.
REQ-034 Deasserting cts_n mid-frame SHALL NOT interrupt the frame; the next frame waits for cts_n=0.
REQ-035 tx_start asserted on the tx_done cycle SHALL be accepted if cts_n=0, giving back-to-back frames with no extra idle bit.
REQ-036 tick=0 SHALL freeze the tick counter, bit counters and tx.

Reset
REQ-037 On rst_n=0 the block SHALL immediately force tx=1, tx_busy=0, tx_done=0, state=IDLE, and clear all counters and latched registers.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no tx_done; the line returns high asynchronously.
REQ-039 After reset release, the block SHALL accept a frame on the first clk with tx_start=1 and cts_n=0.

Verification
REQ-040 8N1: data_bit_num=11, parity_en=0, stop_bit_num=0, tx_data=0xA5, cts_n=0 -> tx bits 0,1,0,1,0,0,1,0,1,1, each held 16 ticks, and tx_done after 160 ticks.
REQ-041 5E1: data_bit_num=00, parity_en=1, parity_type=1, tx_data=0xF3 -> data 1,1,0,0,1, parity 1, stop 1, 128 ticks, with bits 7:5 ignored.
REQ-042 7O2: data_bit_num=10, parity_en=1, parity_type=0, stop_bit_num=1, tx_data=0x00 -> 7 zeros, parity 1, two stop bits, 176 ticks.
REQ-043 Flow control: cts_n=1 with tx_start pulsed -> no frame and tx stays 1. Dropping cts_n mid-frame -> the frame completes unchanged.
REQ-044 Back-to-back: tx_start held high, cts_n=0, 8N1 -> a second start bit begins the clk after tx_done, and inputs changed during frame 1 do not alter it.
REQ-045 Reset mid-DATA: assert rst_n=0 -> tx=1 the same cycle, tx_busy=0 and no tx_done. After release, 0x3C sends correctly.
